operand_b_stage: RTL and testbench

ID/EX pipeline stage for ALU operand B in the pipelined CPU. Captures the decoded rs2 value, sign-extended immediate and operand-B select from decode, resolves rs2 hazards by forwarding from EX/MEM and MEM/WB, and presents the selected operand to the ALU one cycle later. It is the producer side of the operand-B select path: it generates the rs2 and immediate values plus the select that the ALU operand-B mux consumes. It uses a valid/ready handshake so decode stalls cleanly when execute is busy.

---
 rtl/operand_b_stage.sv | 93 +++++++++
 tb/tb_operand_b_stage.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/operand_b_stage.sv
// operand_b_stage: ID/EX pipeline register for ALU operand B with rs2 hazard forwarding.
// Define OPB_FWD_EN to enable EX/MEM and MEM/WB forwarding plus refresh of a held entry.
module operand_b_stage #(
  parameter int WIDTH = 32,
  parameter int REGA  = 5,
  parameter int CNTW  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             id_valid,
  output logic             id_ready,
  input  logic [REGA-1:0]  id_rs2_addr,
  input  logic [WIDTH-1:0] id_rs2_data,
  input  logic [WIDTH-1:0] id_imm,
  input  logic             id_muxopb,
  input  logic             exmem_wr_en,
  input  logic [REGA-1:0]  exmem_rd,
  input  logic [WIDTH-1:0] exmem_data,
  input  logic             memwb_wr_en,
  input  logic [REGA-1:0]  memwb_rd,
  input  logic [WIDTH-1:0] memwb_data,
  output logic             ex_valid,
  input  logic             ex_ready,
  output logic [WIDTH-1:0] ex_ars2,
  output logic [WIDTH-1:0] ex_bimext,
  output logic             ex_muxopb,
  output logic [WIDTH-1:0] ex_opb,
  output logic [CNTW-1:0]  fwd_count
);

  logic [REGA-1:0] rs2_addr_q;
  logic            capture;
  logic            hold;
  // {hit, value} for the incoming instruction and for the held entry.
  logic [WIDTH:0]  cap_res;
  logic [WIDTH:0]  ref_res;

  assign id_ready = !ex_valid || ex_ready;
  assign capture  = id_valid && id_ready && !flush;
  assign hold     = ex_valid && !ex_ready && !flush;
  assign ex_opb   = ex_muxopb ? ex_bimext : ex_ars2;

`ifdef OPB_FWD_EN
  // EX/MEM is the younger writer, so it wins over MEM/WB; x0 never forwards.
  function automatic logic [WIDTH:0] resolve(input logic [REGA-1:0]  addr,
                                             input logic [WIDTH-1:0] raw);
    if (addr != '0 && exmem_wr_en && exmem_rd == addr) return {1'b1, exmem_data};
    if (addr != '0 && memwb_wr_en && memwb_rd == addr) return {1'b1, memwb_data};
    return {1'b0, raw};
  endfunction

  assign cap_res = resolve(id_rs2_addr, id_rs2_data);
  assign ref_res = resolve(rs2_addr_q, ex_ars2);
`else
  logic unused_fwd;

  assign cap_res    = {1'b0, id_rs2_data};
  assign ref_res    = {1'b0, ex_ars2};
  assign unused_fwd = ^{exmem_wr_en, exmem_rd, exmem_data,
                        memwb_wr_en, memwb_rd, memwb_data, rs2_addr_q};
`endif

  // NOTE: all state updates use non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid   <= 1'b0;
      ex_ars2    <= '0;
      ex_bimext  <= '0;
      ex_muxopb  <= 1'b0;
      rs2_addr_q <= '0;
      fwd_count  <= '0;
    end else begin
      if (flush)                    ex_valid <= 1'b0;
      else if (capture)             ex_valid <= 1'b1;
      else if (ex_valid && ex_ready) ex_valid <= 1'b0;

      if (capture) begin
        ex_bimext  <= id_imm;
        ex_muxopb  <= id_muxopb;
        rs2_addr_q <= id_rs2_addr;
        ex_ars2    <= cap_res[WIDTH-1:0];
      end else if (hold && ref_res[WIDTH]) begin
        ex_ars2    <= ref_res[WIDTH-1:0];
      end

      if (((capture && cap_res[WIDTH]) || (hold && ref_res[WIDTH])) && fwd_count != '1)
        fwd_count <= fwd_count + CNTW'(1);
    end
  end

endmodule

// File: tb/tb_operand_b_stage.sv
// Scoreboard bench for operand_b_stage: stimulus pushes expected entries, a monitor
// pops and compares on every ex_valid & ex_ready handshake. Honours OPB_FWD_EN.
module tb_operand_b_stage;

  localparam int WIDTH = 32;
  localparam int REGA  = 5;
  localparam int CNTW  = 2;
`ifdef OPB_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  typedef struct {
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] ars2;
    logic             mux;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             flush;
  logic             id_valid;
  logic             id_ready;
  logic [REGA-1:0]  id_rs2_addr;
  logic [WIDTH-1:0] id_rs2_data;
  logic [WIDTH-1:0] id_imm;
  logic             id_muxopb;
  logic             exmem_wr_en;
  logic [REGA-1:0]  exmem_rd;
  logic [WIDTH-1:0] exmem_data;
  logic             memwb_wr_en;
  logic [REGA-1:0]  memwb_rd;
  logic [WIDTH-1:0] memwb_data;
  logic             ex_valid;
  logic             ex_ready;
  logic [WIDTH-1:0] ex_ars2;
  logic [WIDTH-1:0] ex_bimext;
  logic             ex_muxopb;
  logic [WIDTH-1:0] ex_opb;
  logic [CNTW-1:0]  fwd_count;

  int   checks   = 0;
  int   failures = 0;
  exp_t sb[$];
  logic [CNTW-1:0] exp_cnt;

  operand_b_stage #(.WIDTH(WIDTH), .REGA(REGA), .CNTW(CNTW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_rs2_addr(id_rs2_addr), .id_rs2_data(id_rs2_data),
    .id_imm(id_imm), .id_muxopb(id_muxopb),
    .exmem_wr_en(exmem_wr_en), .exmem_rd(exmem_rd), .exmem_data(exmem_data),
    .memwb_wr_en(memwb_wr_en), .memwb_rd(memwb_rd), .memwb_data(memwb_data),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_ars2(ex_ars2),
    .ex_bimext(ex_bimext), .ex_muxopb(ex_muxopb), .ex_opb(ex_opb),
    .fwd_count(fwd_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [WIDTH-1:0] act,
                       input logic [WIDTH-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [REGA-1:0] a, input logic [WIDTH-1:0] d,
                       input logic [WIDTH-1:0] imm, input logic m);
    id_valid    = v;
    id_rs2_addr = a;
    id_rs2_data = d;
    id_imm      = imm;
    id_muxopb   = m;
  endtask

  task automatic no_fwd();
    exmem_wr_en = 1'b0; exmem_rd = '0; exmem_data = '0;
    memwb_wr_en = 1'b0; memwb_rd = '0; memwb_data = '0;
  endtask

  task automatic expect_entry(input logic [WIDTH-1:0] ars2, input logic [WIDTH-1:0] imm,
                              input logic m);
    exp_t e;
    e.ars2 = ars2;
    e.mux  = m;
    e.opb  = m ? imm : ars2;
    sb.push_back(e);
  endtask

  // Monitor: the handshake completes at the next rising edge, so sample mid-cycle.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && ex_valid === 1'b1 && ex_ready === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected: got opb 0x%0h with empty queue", ex_opb);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_opb", ex_opb, e.opb);
        check("sb_ars2", ex_ars2, e.ars2);
        check("sb_mux", {31'b0, ex_muxopb}, {31'b0, e.mux});
      end
    end
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; ex_ready = 1'b0;
    drive(1'b0, '0, '0, '0, 1'b0);
    no_fwd();
    exp_cnt = '0;
    step(); step();
    check("rst_ex_valid", {31'b0, ex_valid}, 32'd0);
    check("rst_ex_opb", ex_opb, 32'd0);
    check("rst_ex_ars2", ex_ars2, 32'd0);
    check("rst_ex_bimext", ex_bimext, 32'd0);
    check("rst_fwd_count", {30'b0, fwd_count}, 32'd0);
    check("rst_id_ready", {31'b0, id_ready}, 32'd1);
    rst_n = 1'b1;
    step();

    // Immediate selected; rs2 still captured for store data.
    drive(1'b1, 5'd3, 32'h11, 32'hFFFF_FFF0, 1'b1);
    expect_entry(32'h11, 32'hFFFF_FFF0, 1'b1);
    step();
    drive(1'b0, '0, '0, '0, 1'b0);
    check("s1_ex_valid", {31'b0, ex_valid}, 32'd1);
    check("s1_ex_opb", ex_opb, 32'hFFFF_FFF0);
    check("s1_ex_ars2", ex_ars2, 32'h11);
    check("s1_id_ready_held", {31'b0, id_ready}, 32'd0);
    ex_ready = 1'b1;
    step();
    check("s1_drained", {31'b0, ex_valid}, 32'd0);

    // Both writers hit rs2=5; EX/MEM has priority.
    drive(1'b1, 5'd5, 32'h22, 32'h0, 1'b0);
    exmem_wr_en = 1'b1; exmem_rd = 5'd5; exmem_data = 32'hAA;
    memwb_wr_en = 1'b1; memwb_rd = 5'd5; memwb_data = 32'hBB;
    expect_entry(FWD ? 32'hAA : 32'h22, 32'h0, 1'b0);
    if (FWD) exp_cnt = exp_cnt + 2'd1;
    step();
    check("s2_ars2", ex_ars2, FWD ? 32'hAA : 32'h22);
    check("s2_count", {30'b0, fwd_count}, {30'b0, exp_cnt});

    // Address 0 never forwards.
    drive(1'b1, 5'd0, 32'h33, 32'h0, 1'b0);
    exmem_rd = 5'd0; exmem_data = 32'hCC;
    memwb_rd = 5'd0; memwb_data = 32'hDD;
    expect_entry(32'h33, 32'h0, 1'b0);
    step();
    drive(1'b0, '0, '0, '0, 1'b0);
    no_fwd();
    check("s2_x0_ars2", ex_ars2, 32'h33);
    check("s2_x0_count", {30'b0, fwd_count}, {30'b0, exp_cnt});
    step();

    // Held entry is refreshed by a later MEM/WB write to the same register.
    ex_ready = 1'b0;
    drive(1'b1, 5'd7, 32'h01, 32'h100, 1'b0);
    expect_entry(FWD ? 32'h55 : 32'h01, 32'h100, 1'b0);
    step();
    drive(1'b0, '0, '0, '0, 1'b0);
    check("s3_captured", ex_ars2, 32'h01);
    check("s3_id_ready_c1", {31'b0, id_ready}, 32'd0);
    step();
    check("s3_id_ready_c2", {31'b0, id_ready}, 32'd0);
    memwb_wr_en = 1'b1; memwb_rd = 5'd7; memwb_data = 32'h55;
    if (FWD) exp_cnt = exp_cnt + 2'd1;
    step();
    no_fwd();
    check("s3_refreshed", ex_ars2, FWD ? 32'h55 : 32'h01);
    check("s3_count", {30'b0, fwd_count}, {30'b0, exp_cnt});
    check("s3_id_ready_c3", {31'b0, id_ready}, 32'd0);
    step();
    check("s3_still_valid", {31'b0, ex_valid}, 32'd1);
    ex_ready = 1'b1;
    #1;
    check("s3_id_ready_rel", {31'b0, id_ready}, 32'd1);
    step();

    // Back-to-back at full throughput.
    for (int i = 0; i < 4; i++) begin
      logic [WIDTH-1:0] d;
      logic [WIDTH-1:0] imm;
      d   = 32'h100 + 32'(i);
      imm = 32'h200 + 32'(i);
      drive(1'b1, 5'(10 + i), d, imm, i[0]);
      expect_entry(d, imm, i[0]);
      step();
      check("s4_ex_valid", {31'b0, ex_valid}, 32'd1);
      check("s4_ex_opb", ex_opb, i[0] ? imm : d);
    end
    // Flush overrides a simultaneous capture.
    drive(1'b1, 5'd1, 32'h999, 32'h0, 1'b0);
    flush = 1'b1;
    #1;
    check("s4_flush_id_ready", {31'b0, id_ready}, 32'd1);
    step();
    flush = 1'b0;
    drive(1'b0, '0, '0, '0, 1'b0);
    check("s4_flush_valid", {31'b0, ex_valid}, 32'd0);
    step();

    // Counter saturation with a 2-bit counter.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 5'd4, 32'h40, 32'h0, 1'b0);
      exmem_wr_en = 1'b1; exmem_rd = 5'd4; exmem_data = 32'h4000 + 32'(i);
      expect_entry(FWD ? 32'h4000 + 32'(i) : 32'h40, 32'h0, 1'b0);
      if (FWD && exp_cnt != 2'd3) exp_cnt = exp_cnt + 2'd1;
      step();
      check("s5_count", {30'b0, fwd_count}, {30'b0, exp_cnt});
    end
    check("s5_saturated", {30'b0, fwd_count}, FWD ? 32'd3 : 32'd0);
    drive(1'b0, '0, '0, '0, 1'b0);
    no_fwd();
    step(); step(); step();

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
